// File: rtl/isa_test_monitor.sv
// isa_test_monitor: decodes tohost CSR writes into pass/fail verdicts, runs a per-test
// watchdog and sequences NUM_TESTS back-to-back tests into one latched suite verdict.
module isa_test_monitor #(
    parameter int          CYCLE_W        = 32,
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter logic [11:0] TOHOST_ADDR    = 12'h51E,
    parameter int          NUM_TESTS      = 1,
    parameter int          IDX_W          = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               csr_we,
    input  logic [11:0]        csr_addr,
    input  logic [31:0]        csr_wdata,
    output logic               done,
    output logic               pass,
    output logic               fail,
    output logic               timeout,
    output logic [30:0]        fail_id,
    output logic [IDX_W-1:0]   test_idx,
    output logic [CYCLE_W-1:0] test_cycles,
    output logic [CYCLE_W-1:0] total_cycles
);
    typedef enum logic [2:0] {IDLE, RUN, PASS, FAIL, TIMEOUT} state_e;
    localparam int CW = CYCLE_W > 32 ? CYCLE_W : 32;
    state_e             state_q;
    logic               done_q, pass_q, fail_q, timeout_q;
    logic [30:0]        fail_id_q;
    logic [IDX_W-1:0]   test_idx_q;
    logic [CYCLE_W-1:0] test_cycles_q, total_cycles_q, test_cycles_d, total_cycles_d;
    logic               hit, at_budget, last_test;
    always_comb begin
        hit            = csr_we && csr_addr == TOHOST_ADDR && csr_wdata[0];
        test_cycles_d  = &test_cycles_q ? test_cycles_q : test_cycles_q + CYCLE_W'(1);
        total_cycles_d = &total_cycles_q ? total_cycles_q : total_cycles_q + CYCLE_W'(1);
        // widen before comparing so a narrow counter never aliases the budget
        at_budget      = CW'(test_cycles_q) == CW'(TIMEOUT_CYCLES - 1);
        last_test      = test_idx_q + IDX_W'(1) == IDX_W'(NUM_TESTS);
    end
    always_ff @(posedge clk) begin
        if (rst || start) begin
            state_q        <= rst ? IDLE : RUN;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            fail_q         <= 1'b0;
            timeout_q      <= 1'b0;
            fail_id_q      <= '0;
            test_idx_q     <= '0;
            test_cycles_q  <= '0;
            total_cycles_q <= '0;
        end else if (state_q == RUN) begin
            test_cycles_q  <= test_cycles_d;
            total_cycles_q <= total_cycles_d;
            if (hit && csr_wdata[31:1] != '0) begin
                state_q   <= FAIL;
                done_q    <= 1'b1;
                fail_q    <= 1'b1;
                fail_id_q <= csr_wdata[31:1];
            end else if (hit && last_test) begin
                state_q    <= PASS;
                done_q     <= 1'b1;
                pass_q     <= 1'b1;
                test_idx_q <= IDX_W'(NUM_TESTS);
            end else if (hit) begin
                test_idx_q    <= test_idx_q + IDX_W'(1);
                test_cycles_q <= '0;
            end else if (at_budget) begin
                state_q   <= TIMEOUT;
                done_q    <= 1'b1;
                timeout_q <= 1'b1;
            end
        end
    end
    assign done         = done_q;
    assign pass         = pass_q;
    assign fail         = fail_q;
    assign timeout      = timeout_q;
    assign fail_id      = fail_id_q;
    assign test_idx     = test_idx_q;
    assign test_cycles  = test_cycles_q;
    assign total_cycles = total_cycles_q;
endmodule

// File: tb/tb_isa_test_monitor.sv
// tb_isa_test_monitor: directed scoreboard bench over four parameterisations
// (default, short budget, three-test suite, narrow saturating counters).
module tb_isa_test_monitor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0, start_d = 1'b0;
    logic        csr_we = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_wdata = '0;
    int          checks = 0;
    int          errors = 0;

    logic        dn_a, ps_a, fl_a, to_a, dn_b, ps_b, fl_b, to_b;
    logic        dn_c, ps_c, fl_c, to_c, dn_d, ps_d, fl_d, to_d;
    logic [30:0] fid_a, fid_b, fid_c, fid_d;
    logic [7:0]  idx_a, idx_b, idx_c, idx_d;
    logic [31:0] tc_a, tot_a, tc_b, tot_b, tc_c, tot_c;
    logic [3:0]  tc_d, tot_d;

    typedef struct {
        string        tag;
        int           dut;
        logic [106:0] v;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    isa_test_monitor u_a (
        .clk(clk), .rst(rst), .start(start_a), .csr_we(csr_we), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .done(dn_a), .pass(ps_a), .fail(fl_a), .timeout(to_a),
        .fail_id(fid_a), .test_idx(idx_a), .test_cycles(tc_a), .total_cycles(tot_a));
    isa_test_monitor #(.TIMEOUT_CYCLES(20)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .csr_we(csr_we), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .done(dn_b), .pass(ps_b), .fail(fl_b), .timeout(to_b),
        .fail_id(fid_b), .test_idx(idx_b), .test_cycles(tc_b), .total_cycles(tot_b));
    isa_test_monitor #(.TIMEOUT_CYCLES(50), .NUM_TESTS(3)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .csr_we(csr_we), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .done(dn_c), .pass(ps_c), .fail(fl_c), .timeout(to_c),
        .fail_id(fid_c), .test_idx(idx_c), .test_cycles(tc_c), .total_cycles(tot_c));
    isa_test_monitor #(.CYCLE_W(4)) u_d (
        .clk(clk), .rst(rst), .start(start_d), .csr_we(csr_we), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .done(dn_d), .pass(ps_d), .fail(fl_d), .timeout(to_d),
        .fail_id(fid_d), .test_idx(idx_d), .test_cycles(tc_d), .total_cycles(tot_d));

    function automatic logic [106:0] obs(input int d);
        case (d)
            0: return {dn_a, ps_a, fl_a, to_a, fid_a, idx_a, tc_a, tot_a};
            1: return {dn_b, ps_b, fl_b, to_b, fid_b, idx_b, tc_b, tot_b};
            2: return {dn_c, ps_c, fl_c, to_c, fid_c, idx_c, tc_c, tot_c};
            default: return {dn_d, ps_d, fl_d, to_d, fid_d, idx_d, 28'd0, tc_d, 28'd0, tot_d};
        endcase
    endfunction

    // f = {done, pass, fail, timeout}
    task automatic ex(input int d, input string t, input logic [3:0] f, input logic [30:0] fid,
                      input logic [7:0] idx, input logic [31:0] tc, input logic [31:0] tot);
        exp_t e;
        e.tag = t;
        e.dut = d;
        e.v   = {f, fid, idx, tc, tot};
        sb.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic tick_check;
        exp_t e;
        tick();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            assert (obs(e.dut) === e.v) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs(e.dut), e.v);
            end
        end
    endtask

    task automatic csr(input logic we, input logic [11:0] a, input logic [31:0] d);
        csr_we    = we;
        csr_addr  = a;
        csr_wdata = d;
    endtask

    initial begin
        tick();
        for (int d = 0; d < 4; d++) ex(d, "reset", 4'b0000, 0, 0, 0, 0);
        tick_check();
        rst = 1'b0;

        // single test pass with ignored non-hits along the way
        start_a = 1'b1; ex(0, "a_start", 4'b0000, 0, 0, 0, 0); tick_check(); start_a = 1'b0;
        tick(); tick();
        csr(1, 12'h51E, 32'h2); tick();
        csr(1, 12'h300, 32'h1); ex(0, "a_nonhit", 4'b0000, 0, 0, 4, 4); tick_check();
        csr(0, 0, 0);
        repeat (6) tick();
        csr(1, 12'h51E, 32'h1); ex(0, "a_pass", 4'b1100, 0, 1, 11, 11); tick_check();
        csr(1, 12'h51E, 32'hB); ex(0, "a_pass_frozen", 4'b1100, 0, 1, 11, 11); tick_check();
        csr(0, 0, 0);

        // fail id decode, terminal freeze, restart paths
        start_a = 1'b1; ex(0, "a_restart_pass", 4'b0000, 0, 0, 0, 0); tick_check(); start_a = 1'b0;
        tick(); tick();
        csr(1, 12'h51E, 32'hB); ex(0, "a_fail", 4'b1010, 5, 0, 3, 3); tick_check();
        csr(1, 12'h51E, 32'h1); ex(0, "a_fail_frozen", 4'b1010, 5, 0, 3, 3); tick_check();
        csr(0, 0, 0);
        start_a = 1'b1; ex(0, "a_restart_fail", 4'b0000, 0, 0, 0, 0); tick_check(); start_a = 1'b0;
        tick(); tick();
        start_a = 1'b1; csr(1, 12'h51E, 32'hB);
        ex(0, "a_start_over_hit", 4'b0000, 0, 0, 0, 0); tick_check();
        start_a = 1'b0; csr(0, 0, 0);
        repeat (3) tick();
        rst = 1'b1; ex(0, "a_rst_mid_run", 4'b0000, 0, 0, 0, 0); tick_check(); rst = 1'b0;

        // watchdog budget of 20
        start_b = 1'b1; ex(1, "b_start", 4'b0000, 0, 0, 0, 0); tick_check(); start_b = 1'b0;
        repeat (18) tick();
        ex(1, "b_last_budget", 4'b0000, 0, 0, 19, 19); tick_check();
        ex(1, "b_timeout", 4'b1001, 0, 0, 20, 20); tick_check();
        ex(1, "b_timeout_frozen", 4'b1001, 0, 0, 20, 20); tick_check();
        start_b = 1'b1; ex(1, "b_restart", 4'b0000, 0, 0, 0, 0); tick_check(); start_b = 1'b0;
        repeat (19) tick();
        csr(1, 12'h51E, 32'h1); ex(1, "b_hit_on_budget", 4'b1100, 0, 1, 20, 20); tick_check();
        csr(0, 0, 0);

        // three-test suite, each 30 cycles, total exceeds the per-test budget
        start_c = 1'b1; ex(2, "c_start", 4'b0000, 0, 0, 0, 0); tick_check(); start_c = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            repeat (29) tick();
            csr(1, 12'h51E, 32'h1);
            if (k < 3) ex(2, $sformatf("c_test%0d", k), 4'b0000, 0, 8'(k), 0, 32'(30 * k));
            else ex(2, "c_suite_pass", 4'b1100, 0, 3, 30, 90);
            tick_check();
            csr(0, 0, 0);
        end

        // 4-bit counters saturate instead of wrapping
        start_d = 1'b1; ex(3, "d_start", 4'b0000, 0, 0, 0, 0); tick_check(); start_d = 1'b0;
        repeat (19) tick();
        ex(3, "d_saturate", 4'b0000, 0, 0, 15, 15); tick_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/isa_test_monitor.md
Name: isa_test_monitor

Overview:
- Synthesizable, parametrised successor to the ISA bench's pass/fail/timeout check.
- Snoops CPU CSR writes to the tohost CSR and decodes each write as pass or fail(id).
- Runs a per-test watchdog and counts cycles.
- Sequences a suite of NUM_TESTS back-to-back tests, and latches a final verdict for benches or for the FPGA status/UART path.

Parameters:
- CYCLE_W, 32: width of the cycle counters.
- TIMEOUT_CYCLES, 1000: per-test cycle budget, must be ≥2.
- TOHOST_ADDR, 12'h51E: CSR address monitored.
- NUM_TESTS, 1: passes required for suite completion, must be ≥1.
- IDX_W, 8: width of test index/pass count, must satisfy 2^IDX_W > NUM_TESTS.

Ports:
- clk, in, 1: clock, all logic on posedge.
- rst, in, 1: synchronous active-high reset.
- start, in, 1: one-cycle pulse; (re)arms the monitor.
- csr_we, in, 1: CPU CSR write strobe at writeback.
- csr_addr, in, 12: CSR write address.
- csr_wdata, in, 32: CSR write data.
- done, out, 1: verdict latched.
- pass, out, 1: all NUM_TESTS passed.
- fail, out, 1: a test wrote a nonzero fail id.
- timeout, out, 1: a test exceeded TIMEOUT_CYCLES.
- fail_id, out, 31: csr_wdata[31:1] of the failing write.
- test_idx, out, IDX_W: index of the current or terminating test; equals pass_count.
- test_cycles, out, CYCLE_W: cycles elapsed in the current test.
- total_cycles, out, CYCLE_W: cycles since start.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0. Reset overrides every input, including mid-run.
- States: IDLE, RUN, PASS, FAIL, TIMEOUT. done = state∈{PASS,FAIL,TIMEOUT}. pass, fail and timeout are one-hot decodes of the state. All outputs are registered.
- A hit is a cycle with csr_we=1, csr_addr==TOHOST_ADDR and csr_wdata[0]=1. Writes with bit0=0, or to any other address, are ignored.
- IDLE: start=1 → RUN, with test_cycles=0, total_cycles=0, test_idx=0, fail_id=0. Otherwise hold.
- RUN, every cycle: test_cycles and total_cycles increment, saturating at all-ones.
- RUN, hit with wdata[31:1]≠0 → FAIL. fail_id=wdata[31:1]. test_idx unchanged.
- RUN, hit with wdata[31:1]==0:
  - If test_idx+1==NUM_TESTS → PASS, test_idx=NUM_TESTS.
  - Otherwise stay in RUN, test_idx+=1, test_cycles=0.
- RUN, no hit and test_cycles==TIMEOUT_CYCLES-1 → TIMEOUT. Counters freeze at their values after that cycle's increment.
- Priority within a RUN cycle: start > hit > timeout. A hit on the last budget cycle counts as the hit. start in RUN restarts exactly as from IDLE.
- Terminal states: all outputs and counters frozen. start → RUN as from IDLE. Hits are ignored.
- Latency: the verdict is visible on done/pass/fail/timeout on the edge after the hit or budget cycle, i.e. 1 cycle.
- With NUM_TESTS=1, behaviour matches the single-test bench semantics: first hit decides, and status 1 means pass.
- test_cycles never exceeds TIMEOUT_CYCLES. total_cycles saturates and never wraps.

Test Plan:
- Default params: start, 10 idle cycles, then hit with wdata=0x1 → next cycle done=1, pass=1, fail=0, test_idx=1, total_cycles=11.
- Hit with wdata=0x0000000B → fail=1, fail_id=5, test_idx=0. A subsequent hit with wdata=0x1 leaves fail_id=5 and fail=1.
- TIMEOUT_CYCLES=20: start, no hits → timeout=1 on the 21st edge after start, test_cycles=20. Repeat with a hit on budget cycle 20 → pass=1, timeout=0.
- NUM_TESTS=3, TIMEOUT_CYCLES=50: hits (wdata=1) at 30, 30 and 30 cycles into each test → pass=1, test_idx=3, total_cycles=90, no timeout despite total>50.
- Non-hits ignored: csr_we=1 with addr=0x51E and wdata=0x2, then addr=0x300 and wdata=0x1 → remains in RUN with done=0.
- Control corners:
  - rst mid-RUN → all outputs 0 the next cycle.
  - start coincident with a fail hit → RUN with counters 0 and fail=0.
  - start in FAIL → RUN with fail_id=0.
